demux_1to2_buffered: RTL and testbench

- Reverse direction of the datapath 2-to-1 selector: one producer stream is steered to one of two consumer streams by a per-transfer Selector bit.
- Each output channel has a small FIFO, so a stalled consumer does not block transfers to the other channel, as long as that channel has space.
- Sits between a single result source and two sinks, e.g. write-back versus memory-store staging.

---
 rtl/demux_1to2_buffered_pkg.sv | 16 +
 rtl/demux_1to2_buffered_fifo.sv | 72 +++++++
 rtl/demux_1to2_buffered.sv | 78 +++++++
 tb/tb_demux_1to2_buffered.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_1to2_buffered_pkg.sv
// Shared constants for the buffered 1-to-2 demultiplexer: channel select codes
// and FIFO pointer sizing.
package demux_1to2_buffered_pkg;

    localparam int  DEMUX_DEPTH = 2;
    localparam int  PTR_W       = $clog2(DEMUX_DEPTH);

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // Keeps pointer vectors at least one bit wide.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/demux_1to2_buffered_fifo.sv
// sync_fifo_buffer: DEPTH-entry FIFO with a registered head word that holds its
// last value once the FIFO drains (0 after reset).
module sync_fifo_buffer
    import demux_1to2_buffered_pkg::*;
#(
    parameter int NBits = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [NBits-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [NBits-1:0] head
);

    localparam int PW = ptr_width(DEPTH);

    logic [NBits-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head is the word that will be at rd_ptr after this edge; it only changes
    // when a new word becomes visible, so it holds after the last pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head <= '0;
        end else if (do_push && (count == (PW + 1)'(do_pop))) begin
            head <= push_data;
        end else if (do_pop && (count > (PW + 1)'(1))) begin
            head <= mem[rd_ptr + 1'b1];
        end
    end

endmodule

// File: rtl/demux_1to2_buffered.sv
// Steers one producer stream into one of two buffered consumer channels.
// Optional DEMUX_STATS_EN adds per-channel accepted-transfer counters Count0/Count1.
module demux_1to2_buffered
    import demux_1to2_buffered_pkg::*;
#(
    parameter int NBits = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Selector,
    input  logic [NBits-1:0] DataIn,
    input  logic             InValid,
    output logic             InReady,
    output logic [NBits-1:0] Data0,
    output logic             Valid0,
    input  logic             Ready0,
    output logic [NBits-1:0] Data1,
    output logic             Valid1,
    input  logic             Ready1
`ifdef DEMUX_STATS_EN
    ,
    output logic [31:0]      Count0,
    output logic [31:0]      Count1
`endif
);

    logic full0, full1;
    logic empty0, empty1;
    logic accept;
    logic push0, push1;

    assign InReady = (Selector == CH1) ? !full1 : !full0;
    assign accept  = InValid && InReady;
    assign push0   = accept && (Selector == CH0);
    assign push1   = accept && (Selector == CH1);
    assign Valid0  = !empty0;
    assign Valid1  = !empty1;

    sync_fifo_buffer #(.NBits(NBits), .DEPTH(DEPTH)) u_fifo0 (
        .clk       (clk),
        .reset     (reset),
        .push      (push0),
        .push_data (DataIn),
        .pop       (Ready0),
        .full      (full0),
        .empty     (empty0),
        .head      (Data0)
    );

    sync_fifo_buffer #(.NBits(NBits), .DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .reset     (reset),
        .push      (push1),
        .push_data (DataIn),
        .pop       (Ready1),
        .full      (full1),
        .empty     (empty1),
        .head      (Data1)
    );

`ifdef DEMUX_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Count0 <= '0;
            Count1 <= '0;
        end else begin
            if (push0) begin
                Count0 <= Count0 + 1'b1;
            end
            if (push1) begin
                Count1 <= Count1 + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_demux_1to2_buffered.sv
// Self-checking bench for demux_1to2_buffered: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_demux_1to2_buffered;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        Selector;
    logic [31:0] DataIn;
    logic        InValid;
    logic        InReady;
    logic [31:0] Data0, Data1;
    logic        Valid0, Valid1;
    logic        Ready0, Ready1;
`ifdef DEMUX_STATS_EN
    logic [31:0] Count0, Count1;
    logic [31:0] cnt0, cnt1;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] last0, last1;

    always #5 clk = ~clk;

    demux_1to2_buffered #(.NBits(32), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .Selector (Selector),
        .DataIn   (DataIn),
        .InValid  (InValid),
        .InReady  (InReady),
        .Data0    (Data0),
        .Valid0   (Valid0),
        .Ready0   (Ready0),
        .Data1    (Data1),
        .Valid1   (Valid1),
        .Ready1   (Ready1)
`ifdef DEMUX_STATS_EN
        ,
        .Count0   (Count0),
        .Count1   (Count1)
`endif
    );

    wire [66:0] obs = {InReady, Valid0, Data0, Valid1, Data1};

    // Expected {InReady, Valid0, Data0, Valid1, Data1} from the queue model.
    function automatic logic [66:0] model_outs();
        logic        rdy;
        logic [31:0] d0, d1;
        rdy = Selector ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
        d0  = (q0.size() > 0) ? q0[0] : last0;
        d1  = (q1.size() > 0) ? q1[0] : last1;
        return {rdy, q0.size() > 0, d0, q1.size() > 0, d1};
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        last0 = '0;
        last1 = '0;
`ifdef DEMUX_STATS_EN
        cnt0 = '0;
        cnt1 = '0;
`endif
    endtask

    // Advance one clock (called at negedge) and apply the transfer rules to the model.
    task automatic tick();
        logic        pu, po0, po1, sel;
        logic [31:0] d;
        sel = Selector;
        d   = DataIn;
        pu  = InValid && (sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH));
        po0 = Ready0 && (q0.size() > 0);
        po1 = Ready1 && (q1.size() > 0);
        @(posedge clk);
        if (po0) last0 = q0.pop_front();
        if (po1) last1 = q1.pop_front();
        if (pu) begin
            if (sel) begin
                q1.push_back(d);
`ifdef DEMUX_STATS_EN
                cnt1 = cnt1 + 1;
`endif
            end else begin
                q0.push_back(d);
`ifdef DEMUX_STATS_EN
                cnt0 = cnt0 + 1;
`endif
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            Selector = s[0];
            #1;
            checks++;
            if (obs !== model_outs() || InReady !== 1'b1 || Valid0 !== 1'b0 || Valid1 !== 1'b0
                || Data0 !== 32'h0 || Data1 !== 32'h0) begin
                failures++;
                $display("FAIL reset_idle sel=%0d got=%h expected=%h", s, obs, model_outs());
            end
        end
`ifdef DEMUX_STATS_EN
        checks++;
        if (Count0 !== 32'h0 || Count1 !== 32'h0) begin
            failures++;
            $display("FAIL reset_counts got=%h/%h expected=0/0", Count0, Count1);
        end
`endif
    endtask

    task automatic test_single_route();
        Ready0 = 0; Ready1 = 0;
        Selector = 1; DataIn = 32'hDEADBEEF; InValid = 1;
        tick();
        InValid = 0;
        #1;
        checks++;
        if (Valid1 !== 1'b1 || Data1 !== 32'hDEADBEEF || Valid0 !== 1'b0 || obs !== model_outs()) begin
            failures++;
            $display("FAIL single_route got=%h expected=%h", obs, model_outs());
        end
        Ready1 = 1;
        tick();
        Ready1 = 0;
        #1;
        checks++;
        if (Valid1 !== 1'b0 || Data1 !== 32'hDEADBEEF || obs !== model_outs()) begin
            failures++;
            $display("FAIL single_drain got=%h expected=%h", obs, model_outs());
        end
    endtask

    task automatic test_fill_block();
        Ready0 = 0;
        Selector = 0; InValid = 1;
        DataIn = 32'h11; tick();
        DataIn = 32'h22; tick();
        DataIn = 32'h33;
        #1;
        checks++;
        if (InReady !== 1'b0 || obs !== model_outs()) begin
            failures++;
            $display("FAIL full_block_sel0 got=%h expected=%h", obs, model_outs());
        end
        Selector = 1;
        #1;
        checks++;
        if (InReady !== 1'b1 || obs !== model_outs()) begin
            failures++;
            $display("FAIL redirect_sel1 got=%h expected=%h", obs, model_outs());
        end
        tick();
        InValid = 0;
        #1;
        checks++;
        if (Valid1 !== 1'b1 || Data1 !== 32'h33 || Data0 !== 32'h11 || obs !== model_outs()) begin
            failures++;
            $display("FAIL push_ch1_while_ch0_full got=%h expected=%h", obs, model_outs());
        end
    endtask

    task automatic test_drain_order();
        Selector = 0; Ready0 = 1;
        #1;
        checks++;
        if (InReady !== 1'b0 || Data0 !== 32'h11) begin
            failures++;
            $display("FAIL drain_pre got=%h expected InReady=0 Data0=11", obs);
        end
        tick();
        #1;
        checks++;
        if (InReady !== 1'b1 || Valid0 !== 1'b1 || Data0 !== 32'h22 || obs !== model_outs()) begin
            failures++;
            $display("FAIL drain_first got=%h expected=%h", obs, model_outs());
        end
        tick();
        Ready0 = 0;
        #1;
        checks++;
        if (Valid0 !== 1'b0 || Data0 !== 32'h22 || obs !== model_outs()) begin
            failures++;
            $display("FAIL drain_empty got=%h expected=%h", obs, model_outs());
        end
    endtask

    task automatic test_simul_push_pop();
        Selector = 1; Ready1 = 1; InValid = 1; DataIn = 32'h44;
        tick();
        Ready1 = 0; InValid = 0;
        #1;
        checks++;
        if (Valid1 !== 1'b1 || Data1 !== 32'h44 || InReady !== 1'b1 || obs !== model_outs()) begin
            failures++;
            $display("FAIL simul_push_pop got=%h expected=%h", obs, model_outs());
        end
        // One more push must fill the channel, proving occupancy stayed at one.
        InValid = 1; DataIn = 32'h55;
        tick();
        InValid = 0;
        #1;
        checks++;
        if (InReady !== 1'b0 || Data1 !== 32'h44 || obs !== model_outs()) begin
            failures++;
            $display("FAIL simul_occupancy got=%h expected=%h", obs, model_outs());
        end
    endtask

    task automatic test_async_reset();
        Selector = 0; InValid = 1; DataIn = 32'h66;
        tick();
        InValid = 0;
        #2;
        reset = 0;
        #1;
        checks++;
        if (Valid0 !== 1'b0 || Valid1 !== 1'b0 || Data0 !== 32'h0 || Data1 !== 32'h0) begin
            failures++;
            $display("FAIL async_reset got=%h expected V0=0 V1=0 D0=0 D1=0", obs);
        end
`ifdef DEMUX_STATS_EN
        checks++;
        if (Count0 !== 32'h0 || Count1 !== 32'h0) begin
            failures++;
            $display("FAIL async_reset_counts got=%h/%h expected=0/0", Count0, Count1);
        end
`endif
        model_reset();
        @(negedge clk);
        reset = 1;
        Ready0 = 1; Ready1 = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            checks++;
            if (obs !== model_outs() || Valid0 !== 1'b0 || Valid1 !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_empty cyc=%0d got=%h expected=%h", i, obs, model_outs());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            Selector = $urandom_range(0, 1);
            InValid  = ($urandom_range(0, 3) != 0);
            Ready0   = ($urandom_range(0, 2) == 0);
            Ready1   = ($urandom_range(0, 1) == 0);
            DataIn   = $urandom;
            #1;
            checks++;
            if (obs !== model_outs()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h expected=%h", i, obs, model_outs());
            end
`ifdef DEMUX_STATS_EN
            checks++;
            if (Count0 !== cnt0 || Count1 !== cnt1) begin
                failures++;
                $display("FAIL random_counts cyc=%0d got=%h/%h expected=%h/%h", i, Count0, Count1, cnt0, cnt1);
            end
`endif
            tick();
        end
    endtask

    initial begin
        reset = 0; Selector = 0; DataIn = '0; InValid = 0; Ready0 = 0; Ready1 = 0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1;
        @(negedge clk);
        test_reset();
        test_single_route();
        test_fill_block();
        test_drain_order();
        test_simul_push_pop();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
